// File: rtl/calc_dec_pkg.sv
// Shared calculator definitions: ALU op codes, op/button types and the
// calc_dec FSM state encoding, plus the button-to-op encoder mapping.
package calc_dec_pkg;

  typedef logic [3:0] op_t;
  typedef logic [2:0] btn_t;   // {btnl, btnc, btnr}

  localparam op_t OP_ADD = 4'b0000;
  localparam op_t OP_SUB = 4'b0001;
  localparam op_t OP_AND = 4'b0010;
  localparam op_t OP_OR  = 4'b0110;
  localparam op_t OP_XOR = 4'b0100;
  localparam op_t OP_SLT = 4'b1001;
  localparam op_t OP_SLL = 4'b1010;
  localparam op_t OP_SRL = 4'b0101;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Button-to-op encoder used by the calculator front panel.
  function automatic op_t calc_enc(input btn_t btn);
    op_t op;
    case (btn)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SUB;
      3'b010:  op = OP_AND;
      3'b011:  op = OP_OR;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SLT;
      3'b110:  op = OP_SLL;
      default: op = OP_SRL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_dec_lut.sv
// Pure combinational ALU op -> {btnl, btnc, btnr} lookup with a legality flag.
module calc_dec_lut
  import calc_dec_pkg::*;
(
  input  op_t  op,
  output btn_t btn,
  output logic legal
);

  always_comb begin
    btn   = '0;
    legal = 1'b1;
    case (op)
      OP_ADD:  btn = 3'b000;
      OP_SUB:  btn = 3'b001;
      OP_AND:  btn = 3'b010;
      OP_OR:   btn = 3'b011;
      OP_XOR:  btn = 3'b100;
      OP_SLT:  btn = 3'b101;
      OP_SLL:  btn = 3'b110;
      OP_SRL:  btn = 3'b111;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/calc_dec.sv
// Replays an ALU op code as a timed button press with a btnd load strobe.
// Optional loopback re-encode check: define CALC_DEC_LOOPBACK_CHECK_EN.
module calc_dec
  import calc_dec_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [3:0] op_in,
  output logic       op_ready,
  output logic       btnl,
  output logic       btnc,
  output logic       btnr,
  output logic       btnd,
  output logic       busy,
  output logic       done,
  output logic       op_err
`ifdef CALC_DEC_LOOPBACK_CHECK_EN
  ,
  output logic       enc_mismatch
`endif
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
    $error("calc_dec: SETUP_CYCLES must be 1..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("calc_dec: HOLD_CYCLES must be 1..255");
  end

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  btn_t       btn_q, btn_nx;
  logic       err_q, err_nx;
  btn_t       lut_btn;
  logic       lut_legal;
  logic       xfer;

  calc_dec_lut u_lut (
    .op    (op_in),
    .btn   (lut_btn),
    .legal (lut_legal)
  );

  assign op_ready = (state == IDLE) && !reset;
  assign xfer     = op_valid && op_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      btn_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      btn_q <= btn_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    btn_nx   = btn_q;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (lut_legal) begin
            btn_nx   = lut_btn;
            cnt_nx   = SETUP_LD;
            state_nx = SETUP;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) state_nx = STROBE;
        else           cnt_nx   = cnt - 8'd1;
      end
      STROBE: begin
        cnt_nx   = HOLD_LD;
        state_nx = HOLD;
      end
      HOLD: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 8'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Buttons are gated by busy so the idle cycle between presses reads 000.
  assign busy               = (state != IDLE);
  assign {btnl, btnc, btnr} = busy ? btn_q : 3'b000;
  assign btnd               = (state == STROBE);
  assign done               = (state == HOLD) && (cnt == '0);
  assign op_err             = err_q;

`ifdef CALC_DEC_LOOPBACK_CHECK_EN
  op_t  op_q;
  logic mm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      mm_q <= 1'b0;
    end else begin
      if (xfer && lut_legal) op_q <= op_in;
      if (busy && (calc_enc(btn_q) != op_q)) mm_q <= 1'b1;
    end
  end

  assign enc_mismatch = mm_q;
`endif

endmodule

// File: doc/calc_dec.md
# calc_dec

Button-sequence decoder for the calculator datapath; it is the inverse of the button-to-ALU-op encoder. It accepts a 4-bit ALU op code over a valid/ready handshake and maps it back to the matching {btnl, btnc, btnr} combination. It then replays that combination as a timed press with a btnd load strobe, so the calculator can be driven from a script or a serial front-end instead of physical buttons. Codes outside the eight legal encodings are rejected with an error pulse.

## Interface
- SETUP_CYCLES, 2, cycles the buttons are stable before btnd rises; legal range is 1 to 255.
- HOLD_CYCLES, 2, cycles the buttons stay stable after btnd falls; legal range is 1 to 255.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  op_in holds a request.
- op_in  in  4  ALU op code to replay.
- op_ready  out  1  block can accept a request; transfer occurs on op_valid && op_ready.
- btnl, btnc, btnr  out  1 each  decoded button levels.
- btnd  out  1  one-cycle load strobe.
- busy  out  1  a press sequence is in progress.
- done  out  1  one-cycle pulse in the final HOLD cycle.
- op_err  out  1  one-cycle pulse: an illegal code was accepted.
- enc_mismatch  out  1  sticky loopback failure flag; present only with the macro defined, see Configuration.

## Operation
- Decode map, op_in to {l,c,r}:
  - 0000 → 000
  - 0001 → 001
  - 0010 → 010
  - 0110 → 011
  - 0100 → 100
  - 1001 → 101
  - 1010 → 110
  - 0101 → 111
- All other codes are illegal.
- FSM states and transitions:
  - IDLE: op_ready = 1; all buttons are 0.
    - Legal transfer: latch the decoded buttons, load the counter with SETUP_CYCLES-1, go to SETUP.
    - Illegal transfer: pulse op_err next cycle and stay in IDLE; no buttons are driven.
  - SETUP: buttons are driven; the counter counts down; at 0, go to STROBE.
  - STROBE: one cycle, btnd = 1, buttons held; load the counter with HOLD_CYCLES-1, go to HOLD.
  - HOLD: buttons held, btnd = 0; the counter counts down; at 0, done = 1 and go to IDLE next cycle.
- Code 0000 is a legal request: it produces a full sequence with all buttons 0 and a btnd strobe.
- busy = 1 in SETUP, STROBE and HOLD.
- op_ready = (state == IDLE) && !reset. No request is accepted while busy; op_in may change freely while busy.
- Counters are 8 bits wide. Values outside the legal parameter range are a static elaboration error.

## Timing
- Reset values, applied on the clock edge with reset high: state = IDLE, counter = 0, and btnl, btnc, btnr, btnd, busy, done, op_err = 0. enc_mismatch = 0 when compiled in.
- op_ready is 0 while reset is high and 1 on the first cycle after reset is released.
- Legal transfer at edge T:
  - buttons and busy are valid from cycle T+1;
  - btnd is high in cycle T+1+SETUP_CYCLES;
  - done is high in cycle T+1+SETUP_CYCLES+HOLD_CYCLES;
  - op_ready returns in the following cycle, and buttons are 0 in that cycle.
- Total occupancy is SETUP_CYCLES + HOLD_CYCLES + 2 cycles, from transfer edge to next possible transfer edge.
- Back-to-back legal requests have one idle cycle between sequences, with all buttons 0. This guarantees a release edge between presses.
- Illegal transfer at T: op_err is high in cycle T+1; op_ready stays high, so a new transfer at T+1 is allowed.
- Reset mid-sequence aborts immediately: all outputs are 0 on the next edge, and no done or btnd is produced afterwards.
- Reset asserted in the same cycle as op_valid: the request is discarded.

## Configuration
- CALC_DEC_LOOPBACK_CHECK_EN defined:
  - instantiate a combinational re-encoder on the latched buttons;
  - in every SETUP, STROBE and HOLD cycle, compare its output with the latched op code;
  - any difference sets enc_mismatch, which stays high until reset.
- CALC_DEC_LOOPBACK_CHECK_EN undefined: no re-encoder is instantiated and the enc_mismatch port is absent.
- Decode, FSM and timing behaviour are identical either way.

## Structure
- Shared calc package holds:
  - the eight ALU op code constants, named by operation;
  - the 4-bit op type;
  - the 3-bit button-combination type;
  - the FSM state enum (IDLE, SETUP, STROBE, HOLD).
- One natural sub-module: calc_dec_lut, the pure combinational op → {l,c,r, legal} lookup, reused by any future command front-end.
- The loopback re-encoder is the existing calc encoder instantiated unchanged; it is not a new sub-module.

## Test plan
- Sweep all 16 codes (SETUP=2, HOLD=2):
  - each of the eight legal codes drives its mapped buttons, with btnd high exactly 3 cycles after transfer and done high 2 cycles after btnd;
  - each of the eight illegal codes gives a single op_err pulse and no button activity.
- Transfer 0110 and hold op_valid high with 1001 during busy: the second request is accepted only after done + 1 cycle, and buttons read 000 in the gap cycle.
- Reset asserted in the STROBE cycle of 1010: btnd and buttons are 0 on the next edge, no done appears, and op_ready is high on the first cycle after reset falls.
- Set SETUP=1, HOLD=1 and send op 0101: buttons 111 for exactly 3 cycles, btnd in the middle cycle, occupancy 4 cycles.
- Illegal 1111 followed immediately by legal 0001: op_err in cycle T+1, the 0001 transfer accepted at T+1, then btnr alone and a normal strobe.
- Build with CALC_DEC_LOOPBACK_CHECK_EN defined, all legal codes: enc_mismatch stays 0; forcing a latched button bit to flip sets enc_mismatch, and it persists until reset.
